bkg_subtraction_pipe_mc: RTL and testbench

Parametrised successor of the streaming background-subtraction stage. It sits between the sensor frame assembler and the UDP packetiser, with an Avalon-ST sink and an Avalon-ST source. After reset or a recalibrate request, it averages the first BKG_FRAME packets into a per-channel background. In every later packet, it subtracts that background from each channel sample. New in this generation: configurable lanes and sample width, a header pass-through, selectable clamp/signed output, runtime recalibration and bypass.

---
 rtl/bkg_subtraction_pipe_mc.sv | 170 +++++++++++++++++
 tb/tb_bkg_subtraction_pipe_mc.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bkg_subtraction_pipe_mc.sv
// Streaming background subtraction: learns a per-slot/per-lane mean over BKG_FRAME
// packets, then subtracts it from every later packet with a 1-cycle registered output.
module bkg_subtraction_lane #(
   parameter int SAMPLE_W   = 16,
   parameter int ACC_W      = 18,
   parameter int SHIFT      = 2,
   parameter int SIGNED_OUT = 0
) (
   input  logic [SAMPLE_W-1:0] sample,
   input  logic [ACC_W-1:0]    acc,
   output logic [SAMPLE_W-1:0] diff_out,
   output logic [ACC_W-1:0]    acc_sum
);
   logic [ACC_W-1:0]    acc_shr;
   logic [SAMPLE_W-1:0] bkg;
   logic [SAMPLE_W:0]   diff;

   assign acc_shr = acc >> SHIFT;
   assign bkg     = acc_shr[SAMPLE_W-1:0];
   assign diff    = {1'b0, sample} - {1'b0, bkg};
   assign acc_sum = acc + ACC_W'(sample);

   // diff is a (SAMPLE_W+1)-bit two's-complement value; its MSB is the sign
   always_comb begin
      diff_out = diff[SAMPLE_W-1:0];
      if (SIGNED_OUT == 0) begin
         if (diff[SAMPLE_W]) diff_out = '0;
      end else if (diff[SAMPLE_W] && !diff[SAMPLE_W-1]) begin
         diff_out = {1'b1, {(SAMPLE_W-1){1'b0}}};
      end else if (!diff[SAMPLE_W] && diff[SAMPLE_W-1]) begin
         diff_out = {1'b0, {(SAMPLE_W-1){1'b1}}};
      end
   end
endmodule

module bkg_subtraction_pipe_mc #(
   parameter int NUM_WORDS  = 163,
   parameter int HDR_WORDS  = 3,
   parameter int LANES      = 2,
   parameter int SAMPLE_W   = 16,
   parameter int BKG_FRAME  = 4,
   parameter int SIGNED_OUT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_in_data,
   input  logic        data_in_valid,
   output logic        data_in_ready,
   input  logic [1:0]  data_in_empty,
   input  logic        data_in_startofpacket,
   input  logic        data_in_endofpacket,
   output logic [31:0] data_out_data,
   output logic        data_out_valid,
   input  logic        data_out_ready,
   output logic [1:0]  data_out_empty,
   output logic        data_out_startofpacket,
   output logic        data_out_endofpacket,
   input  logic        bypass,
   input  logic        recal,
   output logic        bkg_valid,
   output logic [5:0]  frame_cnt
);
   localparam int SHIFT     = $clog2(BKG_FRAME);
   localparam int ACC_W     = SAMPLE_W + SHIFT;
   localparam int NUM_SLOTS = NUM_WORDS - HDR_WORDS;
   localparam int IDX_W     = $clog2(NUM_WORDS + 1);
   localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

   typedef enum logic [1:0] {LEARN, SUBTRACT, RECAL_PEND} state_t;

   state_t                                     state;
   logic                                       pend_sub;
   logic [IDX_W-1:0]                           word_ctr, idx, slot_full;
   logic [SLOT_W-1:0]                          slot;
   logic [NUM_SLOTS-1:0][LANES-1:0][ACC_W-1:0] acc;
   logic [LANES-1:0][SAMPLE_W-1:0]             sub_res;
   logic [LANES-1:0][ACC_W-1:0]                acc_sum;
   logic accept, eop_acc, is_sample, pkt_open, do_sub, learn_mode, clr;

   // Ready is gated by reset so every output reads 0 while held in reset
   assign data_in_ready = rst & (data_out_ready | ~data_out_valid);
   assign accept        = data_in_valid & data_in_ready;
   assign eop_acc       = accept & data_in_endofpacket;
   assign idx           = data_in_startofpacket ? '0 : word_ctr;
   assign is_sample     = (idx >= IDX_W'(HDR_WORDS)) && (idx < IDX_W'(NUM_WORDS));
   assign slot_full     = idx - IDX_W'(HDR_WORDS);
   assign slot          = slot_full[SLOT_W-1:0];
   assign pkt_open      = (word_ctr != '0) | (accept & data_in_startofpacket);
   assign do_sub        = (state == SUBTRACT) | ((state == RECAL_PEND) & pend_sub);
   assign learn_mode    = (state == LEARN) | ((state == RECAL_PEND) & ~pend_sub);
   assign clr = ((state == LEARN) & recal & (~pkt_open | eop_acc)) |
                ((state == SUBTRACT) & recal & eop_acc) |
                ((state == RECAL_PEND) & eop_acc);

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      bkg_subtraction_lane #(
         .SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W), .SHIFT(SHIFT), .SIGNED_OUT(SIGNED_OUT)
      ) u_lane (
         .sample  (data_in_data[k*SAMPLE_W +: SAMPLE_W]),
         .acc     (acc[slot][k]),
         .diff_out(sub_res[k]),
         .acc_sum (acc_sum[k])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out_data          <= '0;
         data_out_valid         <= 1'b0;
         data_out_empty         <= '0;
         data_out_startofpacket <= 1'b0;
         data_out_endofpacket   <= 1'b0;
         word_ctr               <= '0;
      end else begin
         if (data_in_ready) data_out_valid <= data_in_valid;
         if (accept) begin
            data_out_data          <= (do_sub && is_sample && !bypass) ? sub_res : data_in_data;
            data_out_empty         <= data_in_empty;
            data_out_startofpacket <= data_in_startofpacket;
            data_out_endofpacket   <= data_in_endofpacket;
            if (data_in_endofpacket)              word_ctr <= '0;
            else if (data_in_startofpacket)       word_ctr <= IDX_W'(1);
            else if (word_ctr != IDX_W'(NUM_WORDS)) word_ctr <= word_ctr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) acc <= '0;
      else if (clr) acc <= '0;
      else if (accept && learn_mode && is_sample) acc[slot] <= acc_sum;
   end

   // A recal landing on the closing EOP beat clears right away instead of pending
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= LEARN;
         pend_sub  <= 1'b0;
         bkg_valid <= 1'b0;
         frame_cnt <= '0;
      end else if (clr) begin
         state     <= LEARN;
         pend_sub  <= 1'b0;
         bkg_valid <= 1'b0;
         frame_cnt <= '0;
      end else begin
         case (state)
            LEARN: begin
               if (recal) begin
                  state    <= RECAL_PEND;
                  pend_sub <= 1'b0;
               end else if (eop_acc) begin
                  frame_cnt <= frame_cnt + 1'b1;
                  if (frame_cnt == 6'(BKG_FRAME - 1)) begin
                     state     <= SUBTRACT;
                     bkg_valid <= 1'b1;
                  end
               end
            end
            SUBTRACT: begin
               if (recal) begin
                  state    <= RECAL_PEND;
                  pend_sub <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_bkg_subtraction_pipe_mc.sv
// Scoreboard bench: clamp and signed variants driven in lockstep from one stimulus.
`timescale 1ns/1ps
module tb_bkg_subtraction_pipe_mc;
   localparam int NW  = 163;
   localparam int HDR = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic        in_valid, in_sop, in_eop, out_ready, bypass, recal;
   logic [1:0]  in_empty;
   logic [31:0] dout0, dout1;
   logic        rdy0, rdy1, dv0, dv1, sop0, sop1, eop0, eop1, bkgv0, bkgv1;
   logic [1:0]  emp0, emp1;
   logic [5:0]  fcnt0, fcnt1;

   int total = 0;
   int bad   = 0;
   int bkg_lo, bkg_hi, split;

   typedef struct {
      logic [31:0] d0;
      logic [31:0] d1;
      logic        sop;
      logic        eop;
      logic [1:0]  empty;
   } exp_t;
   exp_t sbq[$];

   always #5 clk = ~clk;

   bkg_subtraction_pipe_mc #(.SIGNED_OUT(0)) u_clamp (
      .clk(clk), .rst(rst),
      .data_in_data(in_data), .data_in_valid(in_valid), .data_in_ready(rdy0),
      .data_in_empty(in_empty), .data_in_startofpacket(in_sop), .data_in_endofpacket(in_eop),
      .data_out_data(dout0), .data_out_valid(dv0), .data_out_ready(out_ready),
      .data_out_empty(emp0), .data_out_startofpacket(sop0), .data_out_endofpacket(eop0),
      .bypass(bypass), .recal(recal), .bkg_valid(bkgv0), .frame_cnt(fcnt0));

   bkg_subtraction_pipe_mc #(.SIGNED_OUT(1)) u_sgn (
      .clk(clk), .rst(rst),
      .data_in_data(in_data), .data_in_valid(in_valid), .data_in_ready(rdy1),
      .data_in_empty(in_empty), .data_in_startofpacket(in_sop), .data_in_endofpacket(in_eop),
      .data_out_data(dout1), .data_out_valid(dv1), .data_out_ready(out_ready),
      .data_out_empty(emp1), .data_out_startofpacket(sop1), .data_out_endofpacket(eop1),
      .bypass(bypass), .recal(recal), .bkg_valid(bkgv1), .frame_cnt(fcnt1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] exp_out(input int idx, input logic [31:0] w,
                                           input bit sub, input bit sgn);
      logic [31:0] r;
      int s, b, d;
      if (!sub || idx < HDR || idx >= NW) return w;
      b = (idx < split) ? bkg_lo : bkg_hi;
      r = '0;
      for (int k = 0; k < 2; k++) begin
         s = int'(w[k*16 +: 16]);
         d = s - b;
         if (!sgn) begin
            if (d < 0) d = 0;
         end else begin
            if (d > 32767)  d = 32767;
            if (d < -32768) d = -32768;
         end
         r[k*16 +: 16] = d[15:0];
      end
      return r;
   endfunction

   task automatic send_pkt(input int n, input logic [31:0] w, input bit sub,
                           input bit eop_en, input int recal_at, input bit gaps);
      exp_t e;
      int   waitc;
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = (i < HDR) ? (32'hA5A5_0000 | 32'(i)) : w;
         in_sop   = (i == 0);
         in_eop   = eop_en && (i == n - 1);
         in_empty = in_eop ? 2'b10 : 2'b00;
         recal    = (i == recal_at);
         waitc    = 0;
         @(negedge clk);
         while (!rdy0 && waitc < 1000) begin
            @(negedge clk);
            waitc++;
         end
         if (!rdy0) begin
            $display("FAIL accept_timeout got=%0d want=1", rdy0);
            $fatal(1);
         end
         e.d0 = exp_out(i, in_data, sub, 1'b0);
         e.d1 = exp_out(i, in_data, sub, 1'b1);
         e.sop = in_sop;
         e.eop = in_eop;
         e.empty = in_empty;
         sbq.push_back(e);
         @(posedge clk); #1;
         recal = 1'b0;
      end
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
      in_empty = 2'b00;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst && dv0 && out_ready) begin
         chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("data_clamp", dout0, e.d0);
            chk("data_signed", dout1, e.d1);
            chk("valid_pair", dv1, 1'b1);
            chk("sop", sop0, e.sop);
            chk("eop", eop0, e.eop);
            chk("empty", emp0, e.empty);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   task automatic chk_reset_outs();
      chk("rst_valid", {dv1, dv0}, 2'b00);
      chk("rst_data0", dout0, 32'h0);
      chk("rst_data1", dout1, 32'h0);
      chk("rst_ready", {rdy1, rdy0}, 2'b00);
      chk("rst_side", {sop0, eop0, emp0, sop1, eop1, emp1}, 8'h00);
      chk("rst_bkgv", {bkgv1, bkgv0}, 2'b00);
      chk("rst_fcnt", {fcnt1, fcnt0}, 12'h000);
   endtask

   task automatic learn4(input logic [31:0] w, input int last_len);
      for (int p = 0; p < 4; p++) begin
         send_pkt((p == 3) ? last_len : NW, w, 1'b0, 1'b1, -1, p == 1);
         if (p < 3) begin
            chk("frame_cnt", fcnt0, 32'(p + 1));
            chk("bkgv_learn", bkgv0, 1'b0);
         end
      end
      chk("bkgv_rise", {bkgv1, bkgv0}, 2'b11);
   endtask

   initial begin
      logic [31:0] held;
      rst = 1'b0; in_data = '0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      in_empty = '0; out_ready = 1'b1; bypass = 1'b0; recal = 1'b0;
      bkg_lo = 16; bkg_hi = 16; split = 1000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outs();
      @(posedge clk); #1;
      rst = 1'b1;

      learn4(32'h0010_0010, NW);

      // subtract packet with a 5-cycle output stall in the middle
      fork
         send_pkt(NW, 32'h0015_0008, 1'b1, 1'b1, -1, 1'b0);
         begin
            repeat (40) @(posedge clk);
            #1 out_ready = 1'b0;
            for (int j = 0; j < 5; j++) begin
               @(negedge clk);
               chk("stall_ready", rdy0, 1'b0);
               if (j == 0) held = dout0;
               else chk("stall_hold", dout0, held);
            end
            @(posedge clk); #1 out_ready = 1'b1;
         end
      join

      bypass = 1'b1;
      send_pkt(NW, 32'h0015_0008, 1'b0, 1'b1, -1, 1'b0);
      bypass = 1'b0;

      send_pkt(NW, 32'h0015_0008, 1'b1, 1'b1, 50, 1'b0);
      chk("bkgv_fall", {bkgv1, bkgv0}, 2'b00);
      chk("fcnt_clear", fcnt0, 6'd0);

      learn4(32'h0020_0020, NW);
      bkg_lo = 32; bkg_hi = 32;
      send_pkt(NW + 2, 32'h0015_0030, 1'b1, 1'b1, -1, 1'b1);

      // reset mid-packet; the last in-flight beat is discarded with it
      send_pkt(60, 32'h0030_0030, 1'b1, 1'b0, -1, 1'b0);
      rst = 1'b0;
      #1;
      chk_reset_outs();
      sbq.delete();
      @(posedge clk); #1;
      rst = 1'b1;

      learn4(32'h0030_0030, 100);
      bkg_lo = 48; bkg_hi = 36; split = 100;
      send_pkt(NW, 32'h0040_0040, 1'b1, 1'b1, -1, 1'b0);

      repeat (5) @(posedge clk);
      chk("sb_drained", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
